thrust_input_ctrl: RTL

Converts the player's thrust controls into the 8-bit `THRUST` value consumed by the Lunar Lander game core. It sits between `hps_io` and the core in the arcade top level. Inputs are the signed analog stick Y axis, the digital joystick up/down bits and PS/2 key events. The block arbitrates between analog and digital sources. In digital mode it ramps a saturating thrust level at a fixed tick rate, so keyboard and d-pad players get usable throttle control.

---
 rtl/thrust_input_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/thrust_input_ctrl.sv
// thrust_input_ctrl
//
// Converts the player's thrust controls into the 8-bit THRUST value used by
// the Lunar Lander core. The stick drives thrust directly while it is being
// used. Keyboard and d-pad players instead ramp a saturating throttle level
// up or down at a fixed tick rate.
//
// Ports
//   clk_25        in   1  system clock (only clock)
//   reset         in   1  synchronous, active-high reset
//   ps2_key       in  11  [10] toggle per key event, [9] pressed,
//                         [8] extended, [7:0] scan code
//   joy_analog_y  in   8  signed stick Y, negative = stick forward
//   joy_up        in   1  digital joystick up (level)
//   joy_down      in   1  digital joystick down (level)
//   thrust        out  8  unsigned thrust, 0 = none, 255 = full
//   analog_mode   out  1  1 while thrust follows the analog stick
module thrust_input_ctrl #(
    parameter int RAMP_DIV  = 104167,
    parameter int RAMP_STEP = 2,
    parameter int DEADZONE  = 8
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  joy_analog_y,
    input  logic        joy_up,
    input  logic        joy_down,
    output logic [7:0]  thrust,
    output logic        analog_mode
);

    localparam int              CW       = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(RAMP_DIV - 1);
    localparam logic [8:0]      STEP9    = 9'(RAMP_STEP);
    localparam logic [7:0]      DZ       = 8'(DEADZONE);

    typedef enum logic {
        DIGITAL = 1'b0,
        ANALOG  = 1'b1
    } mode_t;

    mode_t          state_reg;
    mode_t          state_next;
    logic           toggle_reg;
    logic           key_up_reg;
    logic           key_down_reg;
    logic [CW-1:0]  count_reg;
    logic [7:0]     level_reg;
    logic [7:0]     level_next;
    logic           analog_mode_reg;

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic       key_event;
    logic [8:0] key_code;
    logic       code_is_up;
    logic       code_is_down;

    assign key_event    = (toggle_reg != ps2_key[10]);
    assign key_code     = {ps2_key[8], ps2_key[7:0]};
    assign code_is_up   = (key_code == 9'h175) || (key_code == 9'h01D);
    assign code_is_down = (key_code == 9'h172) || (key_code == 9'h01B);

    // ------------------------------------------------------------------
    // Request combine, analog map and activity
    // ------------------------------------------------------------------
    logic       up_any;
    logic       dn_any;
    logic [8:0] a_map9;
    logic [7:0] a_map;
    logic [7:0] a_mag;
    logic       a_act;
    logic       tick;

    assign up_any = key_up_reg | joy_up;
    assign dn_any = key_down_reg | joy_down;

    // 127 - s evaluated at 9 bits always lands in 0..255.
    assign a_map9 = 9'd127 - {joy_analog_y[7], joy_analog_y};
    assign a_map  = a_map9[7:0];

    // 8-bit magnitude: -128 becomes 0x80, i.e. 128 as unsigned.
    assign a_mag = joy_analog_y[7] ? 8'(~joy_analog_y + 8'd1) : joy_analog_y;
    assign a_act = (a_mag >= DZ);

    assign tick = (count_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state and next-level logic
    // ------------------------------------------------------------------
    logic [8:0] sum9;
    logic [8:0] diff9;

    assign sum9  = {1'b0, level_reg} + STEP9;
    assign diff9 = {1'b0, level_reg} - STEP9;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DIGITAL: if (a_act && !up_any && !dn_any) state_next = ANALOG;
            ANALOG:  if (up_any || dn_any)            state_next = DIGITAL;
            default: state_next = DIGITAL;
        endcase
    end

    always_comb begin
        level_next = level_reg;
        if (state_next == ANALOG) begin
            // Track the stick continuously so a later switch to digital
            // starts ramping from where the stick left off.
            level_next = a_map;
        end else if (state_reg == DIGITAL && tick) begin
            // The ANALOG->DIGITAL edge itself holds; ramping starts at the
            // next tick in DIGITAL.
            if (up_any && !dn_any) begin
                level_next = sum9[8] ? 8'hFF : sum9[7:0];
            end else if (dn_any && !up_any) begin
                level_next = diff9[8] ? 8'h00 : diff9[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_reg       <= DIGITAL;
            toggle_reg      <= ps2_key[10];
            key_up_reg      <= 1'b0;
            key_down_reg    <= 1'b0;
            count_reg       <= '0;
            level_reg       <= 8'd0;
            analog_mode_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            toggle_reg      <= ps2_key[10];
            level_reg       <= level_next;
            analog_mode_reg <= (state_next == ANALOG);

            if (key_event) begin
                if (code_is_up)   key_up_reg   <= ps2_key[9];
                if (code_is_down) key_down_reg <= ps2_key[9];
            end

            count_reg <= tick ? '0 : count_reg + 1'b1;
        end
    end

    assign thrust      = level_reg;
    assign analog_mode = analog_mode_reg;

endmodule
